// File: rtl/rob_allocator_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rob_allocator_pkg
//  Description : Shared types and sizing constants for the ROB dispatch front
//                end: dispatch request lane and ROB row layouts.
//  Revision    : 1.0 - initial release
// ============================================================================
package rob_allocator_pkg;

    localparam int ROB_DEPTH = 16;
    localparam int ROB_IDX_W = 4;
    localparam int CNT_W     = 5;
    localparam int PREG_W    = 6;
    localparam int DATA_W    = 32;

    // One rename lane presented to the allocator
    typedef struct packed {
        logic              valid;
        logic [PREG_W-1:0] PRegAddrDst;
        logic [PREG_W-1:0] OldPRegAddrDst;
        logic              RegWrite;
        logic              MemWrite;
    } dispatch_req_struct;

    // ROB entry as seen on the ROB issue and retire ports
    typedef struct packed {
        logic                 valid;
        logic                 complete;
        logic [ROB_IDX_W-1:0] ROBNumber;
        logic [PREG_W-1:0]    PRegAddrDst;
        logic [PREG_W-1:0]    OldPRegAddrDst;
        logic                 RegWrite;
        logic                 MemWrite;
        logic [DATA_W-1:0]    data;
    } rob_row_struct;

    // Next ROB number, wrapping naturally at ROB_DEPTH
    function automatic logic [ROB_IDX_W-1:0] rob_inc(input logic [ROB_IDX_W-1:0] idx);
        return idx + 1'b1;
    endfunction

    // Formats a new ROB entry; a non-accepted lane yields an all-zero row
    function automatic rob_row_struct build_row(
        input logic                 accept,
        input dispatch_req_struct   req,
        input logic [ROB_IDX_W-1:0] num
    );
        rob_row_struct row;
        row = '0;
        if (accept) begin
            row.valid          = 1'b1;
            row.ROBNumber      = num;
            row.PRegAddrDst    = req.PRegAddrDst;
            row.OldPRegAddrDst = req.OldPRegAddrDst;
            row.RegWrite       = req.RegWrite;
            row.MemWrite       = req.MemWrite;
        end
        return row;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rob_ptr_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : rob_ptr_ctr
//  Description : Head / tail / occupancy bookkeeping for the ROB. Pointers
//                wrap modulo ROB_DEPTH; full vs. empty is told by the count.
//  Revision    : 1.0 - initial release
// ============================================================================
module rob_ptr_ctr
    import rob_allocator_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [1:0]           i_n_alloc,
    input  logic [1:0]           i_n_retire,
    output logic [ROB_IDX_W-1:0] o_head,
    output logic [ROB_IDX_W-1:0] o_tail,
    output logic [CNT_W-1:0]     o_count
);

    logic [ROB_IDX_W-1:0] r_head;
    logic [ROB_IDX_W-1:0] r_tail;
    logic [CNT_W-1:0]     r_count;

    // Advance pointers by the number of entries allocated / freed this cycle
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + ROB_IDX_W'(i_n_retire);
            r_tail  <= r_tail + ROB_IDX_W'(i_n_alloc);
            r_count <= r_count + CNT_W'(i_n_alloc) - CNT_W'(i_n_retire);
        end
    end

    assign o_head  = r_head;
    assign o_tail  = r_tail;
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/rob_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : rob_allocator
//  Description : Dispatch-side ROB front end. Assigns in-order ROB numbers to
//                up to two renamed instructions per cycle, emits them as new
//                ROB rows one cycle later, and frees slots from the ROB's two
//                retire rows, flagging out-of-order retires.
//  Revision    : 1.0 - initial release
// ============================================================================
module rob_allocator
    import rob_allocator_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  dispatch_req_struct   i_disp_req    [0:1],
    output logic                 o_disp_ready,
    output rob_row_struct        o_rob_row     [0:1],
    input  rob_row_struct        i_retire_rows [0:1],
    output logic [ROB_IDX_W-1:0] o_head,
    output logic [CNT_W-1:0]     o_count,
    output logic                 o_empty,
    output logic                 o_order_error
);

    logic [ROB_IDX_W-1:0] w_head;
    logic [ROB_IDX_W-1:0] w_tail;
    logic [CNT_W-1:0]     w_count;
    logic                 w_ready;
    logic                 w_acc0;
    logic                 w_acc1;
    logic [ROB_IDX_W-1:0] w_num [0:1];
    logic                 w_acc [0:1];
    logic [1:0]           w_n_alloc;
    logic                 w_ret_ok0;
    logic                 w_ret_ok1;
    logic                 w_ret_err;
    logic [1:0]           w_n_retire;
    logic [ROB_IDX_W-1:0] w_exp1;
    logic [CNT_W-1:0]     w_occ1;
    rob_row_struct        r_rob_row [0:1];
    logic                 r_order_error;

    rob_ptr_ctr u_ptr_ctr (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_n_alloc  (w_n_alloc),
        .i_n_retire (w_n_retire),
        .o_head     (w_head),
        .o_tail     (w_tail),
        .o_count    (w_count)
    );

    // Room for two is judged from the registered count only; retires this
    // cycle do not open space until the next cycle.
    assign w_ready = (w_count <= CNT_W'(ROB_DEPTH - 2));

    // Lane compaction: the first accepted lane takes tail, the second tail+1
    assign w_acc0    = i_disp_req[0].valid & w_ready;
    assign w_acc1    = i_disp_req[1].valid & w_ready;
    assign w_acc[0]  = w_acc0;
    assign w_acc[1]  = w_acc1;
    assign w_num[0]  = w_tail;
    assign w_num[1]  = w_acc0 ? rob_inc(w_tail) : w_tail;
    assign w_n_alloc = {1'b0, w_acc0} + {1'b0, w_acc1};

    // Retire checks: row 0 must match head, row 1 must match the next oldest;
    // a bad row is dropped and flagged without blocking the other row.
    always_comb begin
        w_ret_ok0 = 1'b0;
        w_ret_ok1 = 1'b0;
        w_ret_err = 1'b0;
        w_exp1    = w_head;
        w_occ1    = w_count;
        if (i_retire_rows[0].valid) begin
            if ((w_count == '0) || (i_retire_rows[0].ROBNumber != w_head)) begin
                w_ret_err = 1'b1;
            end else begin
                w_ret_ok0 = 1'b1;
            end
        end
        if (w_ret_ok0) begin
            w_exp1 = rob_inc(w_head);
            w_occ1 = w_count - 1'b1;
        end
        if (i_retire_rows[1].valid) begin
            if ((w_occ1 == '0) || (i_retire_rows[1].ROBNumber != w_exp1)) begin
                w_ret_err = 1'b1;
            end else begin
                w_ret_ok1 = 1'b1;
            end
        end
    end

    assign w_n_retire = {1'b0, w_ret_ok0} + {1'b0, w_ret_ok1};

    generate
        for (genvar g = 0; g < 2; g++) begin : g_lane
            // Register the formatted ROB row for this lane
            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    r_rob_row[g] <= '0;
                end else begin
                    r_rob_row[g] <= build_row(w_acc[g], i_disp_req[g], w_num[g]);
                end
            end
            assign o_rob_row[g] = r_rob_row[g];
        end
    endgenerate

    // Sticky out-of-order flag, cleared only by reset
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_order_error <= 1'b0;
        end else if (w_ret_err) begin
            r_order_error <= 1'b1;
        end
    end

    assign o_disp_ready  = w_ready;
    assign o_head        = w_head;
    assign o_count       = w_count;
    assign o_empty       = (w_count == '0);
    assign o_order_error = r_order_error;

    // Only valid and ROBNumber of a retire row matter here
    logic w_unused_retire;
    assign w_unused_retire = ^{i_retire_rows[0].complete, i_retire_rows[0].PRegAddrDst,
                               i_retire_rows[0].OldPRegAddrDst, i_retire_rows[0].RegWrite,
                               i_retire_rows[0].MemWrite, i_retire_rows[0].data,
                               i_retire_rows[1].complete, i_retire_rows[1].PRegAddrDst,
                               i_retire_rows[1].OldPRegAddrDst, i_retire_rows[1].RegWrite,
                               i_retire_rows[1].MemWrite, i_retire_rows[1].data};

    a_ptr_invariant: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        w_tail == ROB_IDX_W'(w_head + w_count[ROB_IDX_W-1:0]));

    a_count_bound: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        w_count <= CNT_W'(ROB_DEPTH));

endmodule
`default_nettype wire

// File: tb/tb_rob_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rob_allocator
//  Description : Directed self-checking bench for rob_allocator.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rob_allocator;
    import rob_allocator_pkg::*;

    logic                 clk;
    logic                 rst_n;
    dispatch_req_struct   disp [0:1];
    rob_row_struct        rows [0:1];
    rob_row_struct        ret  [0:1];
    logic                 ready;
    logic [ROB_IDX_W-1:0] head;
    logic [CNT_W-1:0]     count;
    logic                 empty;
    logic                 err;
    int                   n_checks;
    int                   n_fail;

    rob_allocator dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_disp_req    (disp),
        .o_disp_ready  (ready),
        .o_rob_row     (rows),
        .i_retire_rows (ret),
        .o_head        (head),
        .o_count       (count),
        .o_empty       (empty),
        .o_order_error (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_disp(input logic v0, input logic v1, input int base);
        disp[0]                = '0;
        disp[0].valid          = v0;
        disp[0].PRegAddrDst    = 6'(base);
        disp[0].OldPRegAddrDst = 6'(base + 32);
        disp[0].RegWrite       = 1'b1;
        disp[1]                = '0;
        disp[1].valid          = v1;
        disp[1].PRegAddrDst    = 6'(base + 1);
        disp[1].OldPRegAddrDst = 6'(base + 33);
        disp[1].MemWrite       = 1'b1;
    endtask

    task automatic set_ret(input logic v0, input int n0, input logic v1, input int n1);
        ret[0]           = '0;
        ret[0].valid     = v0;
        ret[0].complete  = 1'b1;
        ret[0].ROBNumber = 4'(n0);
        ret[1]           = '0;
        ret[1].valid     = v1;
        ret[1].complete  = 1'b1;
        ret[1].ROBNumber = 4'(n1);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        set_disp(1'b0, 1'b0, 0);
        set_ret(1'b0, 0, 1'b0, 0);

        // Reset held two cycles
        step();
        step();
        check_val("rst_count", 32'(count), 0);
        check_val("rst_head", 32'(head), 0);
        check_val("rst_ready", 32'(ready), 1);
        check_val("rst_empty", 32'(empty), 1);
        check_val("rst_row0_valid", 32'(rows[0].valid), 0);
        check_val("rst_row1_valid", 32'(rows[1].valid), 0);
        check_val("rst_err", 32'(err), 0);
        rst_n = 1'b1;

        // Fill with 8 dual dispatches
        for (int i = 0; i < 8; i++) begin
            check_val("fill_ready_before", 32'(ready), 1);
            set_disp(1'b1, 1'b1, 2 * i + 10);
            step();
            check_val("fill_row0_num", 32'(rows[0].ROBNumber), 32'(2 * i));
            check_val("fill_row1_num", 32'(rows[1].ROBNumber), 32'(2 * i + 1));
            check_val("fill_row0_valid", 32'(rows[0].valid), 1);
            check_val("fill_row1_valid", 32'(rows[1].valid), 1);
            check_val("fill_row0_preg", 32'(rows[0].PRegAddrDst), 32'(2 * i + 10));
            check_val("fill_row1_old", 32'(rows[1].OldPRegAddrDst), 32'(2 * i + 43));
            check_val("fill_row1_memw", 32'(rows[1].MemWrite), 1);
            check_val("fill_row0_cmpl", 32'(rows[0].complete), 0);
            check_val("fill_count", 32'(count), 32'(2 * i + 2));
        end
        check_val("full_ready", 32'(ready), 0);
        check_val("full_empty", 32'(empty), 0);

        // Ninth request held while full
        step();
        check_val("held_row0_valid", 32'(rows[0].valid), 0);
        check_val("held_row1_valid", 32'(rows[1].valid), 0);
        check_val("held_row0_num", 32'(rows[0].ROBNumber), 0);
        check_val("held_row0_preg", 32'(rows[0].PRegAddrDst), 0);
        check_val("held_count", 32'(count), 16);

        // Wrap: retire #0,#1 from full
        set_disp(1'b0, 1'b0, 0);
        set_ret(1'b1, 0, 1'b1, 1);
        step();
        check_val("wrap_count", 32'(count), 14);
        check_val("wrap_head", 32'(head), 2);
        check_val("wrap_ready", 32'(ready), 1);
        check_val("wrap_err", 32'(err), 0);
        set_ret(1'b0, 0, 1'b0, 0);
        set_disp(1'b1, 1'b1, 40);
        step();
        check_val("wrap_row0_num", 32'(rows[0].ROBNumber), 0);
        check_val("wrap_row1_num", 32'(rows[1].ROBNumber), 1);
        check_val("wrap_count_full", 32'(count), 16);

        // Lane1-only at tail=5
        rst_n = 1'b0;
        set_disp(1'b0, 1'b0, 0);
        step();
        rst_n = 1'b1;
        check_val("rst2_count", 32'(count), 0);
        set_disp(1'b1, 1'b1, 0);
        step();
        step();
        set_disp(1'b1, 1'b0, 0);
        step();
        check_val("l0only_num", 32'(rows[0].ROBNumber), 4);
        check_val("l0only_row1_valid", 32'(rows[1].valid), 0);
        set_disp(1'b0, 1'b1, 20);
        step();
        check_val("l1only_num", 32'(rows[1].ROBNumber), 5);
        check_val("l1only_row0_valid", 32'(rows[0].valid), 0);
        check_val("l1only_preg", 32'(rows[1].PRegAddrDst), 21);
        set_disp(1'b1, 1'b1, 24);
        step();
        check_val("after_l1_row0", 32'(rows[0].ROBNumber), 6);
        check_val("after_l1_row1", 32'(rows[1].ROBNumber), 7);
        check_val("after_l1_count", 32'(count), 8);
        set_disp(1'b0, 1'b0, 0);

        // In-order retire, then an out-of-order one
        set_ret(1'b1, 0, 1'b1, 1);
        step();
        check_val("ret01_head", 32'(head), 2);
        check_val("ret01_count", 32'(count), 6);
        set_ret(1'b1, 7, 1'b0, 0);
        step();
        check_val("ooo_err", 32'(err), 1);
        check_val("ooo_count", 32'(count), 6);
        check_val("ooo_head", 32'(head), 2);
        set_ret(1'b1, 2, 1'b1, 3);
        step();
        check_val("sticky_err", 32'(err), 1);
        check_val("ret23_head", 32'(head), 4);
        set_ret(1'b1, 4, 1'b0, 0);
        step();
        check_val("ret4_count", 32'(count), 3);

        // Simultaneous dual dispatch + one retire at count=3
        set_disp(1'b1, 1'b1, 30);
        set_ret(1'b1, 5, 1'b0, 0);
        step();
        check_val("sim_count", 32'(count), 4);
        check_val("sim_head", 32'(head), 6);
        check_val("sim_row0_num", 32'(rows[0].ROBNumber), 8);
        check_val("sim_row1_num", 32'(rows[1].ROBNumber), 9);
        set_disp(1'b0, 1'b0, 0);

        // Row 0 good, row 1 out of order: only row 0 frees
        set_ret(1'b1, 6, 1'b1, 9);
        step();
        check_val("split_head", 32'(head), 7);
        check_val("split_count", 32'(count), 3);
        set_ret(1'b0, 0, 1'b0, 0);

        // Build count 9, then reset mid-run
        set_disp(1'b1, 1'b1, 0);
        step();
        step();
        step();
        check_val("pre_rst_count", 32'(count), 9);
        check_val("pre_rst_row1_num", 32'(rows[1].ROBNumber), 15);
        rst_n = 1'b0;
        set_disp(1'b0, 1'b0, 0);
        step();
        rst_n = 1'b1;
        check_val("mid_rst_err", 32'(err), 0);
        check_val("mid_rst_count", 32'(count), 0);
        check_val("mid_rst_head", 32'(head), 0);
        check_val("mid_rst_row0_valid", 32'(rows[0].valid), 0);
        set_disp(1'b1, 1'b1, 50);
        step();
        check_val("post_rst_row0_num", 32'(rows[0].ROBNumber), 0);
        check_val("post_rst_row1_num", 32'(rows[1].ROBNumber), 1);
        set_disp(1'b0, 1'b0, 0);

        // Drain, then retire while empty
        set_ret(1'b1, 0, 1'b1, 1);
        step();
        check_val("drain_count", 32'(count), 0);
        check_val("drain_err", 32'(err), 0);
        set_ret(1'b1, 2, 1'b0, 0);
        step();
        check_val("empty_ret_err", 32'(err), 1);
        check_val("empty_ret_count", 32'(count), 0);
        check_val("empty_ret_head", 32'(head), 2);
        check_val("empty_ret_empty", 32'(empty), 1);
        set_ret(1'b0, 0, 1'b0, 0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
